uart_tx_arbiter: RTL

- Round-robin scheduler that shares one uart_tx instance between NUM_REQ sample producers.
- Each granted 16-bit sample is serialised as a framed byte sequence: a header byte, then MSB, then LSB, plus an optional checksum byte.
- Drives the uart_tx byte-valid/byte inputs and sequences each byte off the uart_tx Active/Done outputs.
- Sits between the sample sources and uart_tx in the sample-to-UART path.

---
 rtl/uart_tx_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin scheduler that shares one uart_tx between NUM_REQ sample
//   producers. Each granted 16-bit sample goes out as a framed byte sequence:
//   header {HDR_TAG, idx[3:0]}, MSB, LSB, and optionally a checksum byte.
//
//   Build option: define UART_ARB_CHECKSUM_EN to append a 4th byte equal to
//   header ^ MSB ^ LSB. Without it the frame is 3 bytes and no checksum logic
//   is built.
//
// Ports
//   in_Clock       system clock
//   in_Reset       asynchronous, active-high reset
//   in_Req         per-requester sample valid, held until the matching Ack
//   in_Data        16 bits per requester, requester i at [16*i+15:16*i]
//   out_Ack        one-cycle pulse when requester i's sample is latched
//   out_Tx_DV      byte-valid pulse to uart_tx
//   out_Tx_Byte    byte to uart_tx
//   in_Tx_Active   uart_tx out_Tx_Active
//   in_Tx_Done     uart_tx out_Tx_Done
//   out_Busy       high whenever the scheduler is not idle
//   out_Frame_Cnt  completed frame count, wraps

module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter logic [3:0]  HDR_TAG = 4'hA
) (
   input  logic                    in_Clock,
   input  logic                    in_Reset,
   input  logic [NUM_REQ-1:0]      in_Req,
   input  logic [16*NUM_REQ-1:0]   in_Data,
   output logic [NUM_REQ-1:0]      out_Ack,
   output logic                    out_Tx_DV,
   output logic [7:0]              out_Tx_Byte,
   input  logic                    in_Tx_Active,
   input  logic                    in_Tx_Done,
   output logic                    out_Busy,
   output logic [15:0]             out_Frame_Cnt
);

   localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef UART_ARB_CHECKSUM_EN
   localparam logic [1:0] LAST_BYTE = 2'd3;
`else
   localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_LOAD,
      ST_WAIT_START,
      ST_WAIT_DONE,
      ST_RELEASE
   } state_t;

   state_t          state;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  cur_idx;
   logic [15:0]     cur_data;
   logic [1:0]      byte_idx;

   logic [15:0]     req_word [NUM_REQ];
   logic            sel_found;
   logic [IDW-1:0]  sel_idx;
   logic [IDW-1:0]  next_ptr;
   logic [7:0]      hdr_byte;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_word[g] = in_Data[16*g +: 16];
   end

   // First requester at or after rr_ptr; the wrap is an explicit subtract so
   // non power-of-two NUM_REQ works.
   always_comb begin : p_select
      int unsigned cand;
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = 32'(rr_ptr) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!sel_found && in_Req[IDW'(cand)]) begin
            sel_found = 1'b1;
            sel_idx   = IDW'(cand);
         end
      end
   end

   always_comb begin
      next_ptr = (sel_idx == IDW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
      hdr_byte = {HDR_TAG, 4'(cur_idx)};
   end

   always_ff @(posedge in_Clock or posedge in_Reset) begin
      if (in_Reset) begin
         state         <= ST_IDLE;
         rr_ptr        <= '0;
         cur_idx       <= '0;
         cur_data      <= '0;
         byte_idx      <= '0;
         out_Ack       <= '0;
         out_Tx_DV     <= 1'b0;
         out_Tx_Byte   <= '0;
         out_Busy      <= 1'b0;
         out_Frame_Cnt <= '0;
      end else begin
         out_Ack   <= '0;
         out_Tx_DV <= 1'b0;
         case (state)
            // uart_tx has no reset: a byte in flight across our reset must
            // drain (Active and Done both low) before a new grant.
            ST_IDLE: begin
               if ((|in_Req) && !in_Tx_Active && !in_Tx_Done) begin
                  state    <= ST_GRANT;
                  out_Busy <= 1'b1;
               end
            end
            ST_GRANT: begin
               if (sel_found) begin
                  cur_idx          <= sel_idx;
                  cur_data         <= req_word[sel_idx];
                  out_Ack[sel_idx] <= 1'b1;
                  rr_ptr           <= next_ptr;
                  byte_idx         <= '0;
                  state            <= ST_LOAD;
               end else begin
                  state    <= ST_IDLE;
                  out_Busy <= 1'b0;
               end
            end
            ST_LOAD: begin
               case (byte_idx)
                  2'd0:    out_Tx_Byte <= hdr_byte;
                  2'd1:    out_Tx_Byte <= cur_data[15:8];
                  2'd2:    out_Tx_Byte <= cur_data[7:0];
`ifdef UART_ARB_CHECKSUM_EN
                  default: out_Tx_Byte <= hdr_byte ^ cur_data[15:8] ^ cur_data[7:0];
`else
                  default: out_Tx_Byte <= '0;
`endif
               endcase
               out_Tx_DV <= 1'b1;
               state     <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               if (in_Tx_Active) state <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (in_Tx_Done) state <= ST_RELEASE;
            end
            // Wait out the whole Done pulse so the next DV meets an idle uart_tx.
            ST_RELEASE: begin
               if (!in_Tx_Done) begin
                  if (byte_idx == LAST_BYTE) begin
                     out_Frame_Cnt <= out_Frame_Cnt + 16'd1;
                     state         <= ST_IDLE;
                     out_Busy      <= 1'b0;
                  end else begin
                     byte_idx <= byte_idx + 2'd1;
                     state    <= ST_LOAD;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               out_Busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
